// File: rtl/lsu_rmw_pkg.sv
// lsu_rmw_pkg: funct3 encodings, FSM states and big-endian lane helpers for the LSU.
package lsu_rmw_pkg;
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;
  localparam logic [4:0] LANE0_LSB = 5'd24;
  localparam logic [4:0] LANE1_LSB = 5'd16;
  localparam logic [4:0] LANE2_LSB = 5'd8;
  localparam logic [4:0] LANE3_LSB = 5'd0;
  function automatic logic [4:0] byte_lsb(input logic [1:0] off);
    return off == 2'd0 ? LANE0_LSB : off == 2'd1 ? LANE1_LSB : off == 2'd2 ? LANE2_LSB : LANE3_LSB;
  endfunction
  function automatic logic [4:0] half_lsb(input logic [1:0] off);
    return off[1] ? LANE3_LSB : LANE1_LSB;
  endfunction
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    return f3 == LSU_W ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: extracts/extends a load lane and merges store data into a big-endian word.
module lsu_lane_align
  import lsu_rmw_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merged_o
);
  logic [4:0]  bs, hs;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    bs = byte_lsb(off_i);
    hs = half_lsb(off_i);
    b  = 8'(word_i >> bs);
    h  = 16'(word_i >> hs);
    load_o = funct3_i == LSU_B  ? {{(XLEN-8){b[7]}}, b} :
             funct3_i == LSU_BU ? {{(XLEN-8){1'b0}}, b} :
             funct3_i == LSU_H  ? {{(XLEN-16){h[15]}}, h} :
             funct3_i == LSU_HU ? {{(XLEN-16){1'b0}}, h} :
             funct3_i == LSU_W  ? word_i : '0;
    merged_o = funct3_i[1:0] == 2'b00 ?
                 (word_i & ~({{(XLEN-8){1'b0}}, 8'hFF} << bs)) | ({{(XLEN-8){1'b0}}, wdata_i[7:0]} << bs) :
               funct3_i[1:0] == 2'b01 ?
                 (word_i & ~({{(XLEN-16){1'b0}}, 16'hFFFF} << hs)) | ({{(XLEN-16){1'b0}}, wdata_i[15:0]} << hs) :
                 wdata_i;
  end
endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store initiator for a word-only RAM port; sub-word stores use read-modify-write.
module lsu_rmw
  import lsu_rmw_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic [XLEN-1:0] ram_data_o,
  output logic            mem_we_o,
  input  logic [XLEN-1:0] ram_data_i
);
  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d, err_q, err_d;
  logic [XLEN-1:0]   load_v, merged_v;
  logic              acc, f3_ok, bad;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .word_i   (ram_data_i),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .wdata_i  (wdata_q),
    .load_o   (load_v),
    .merged_o (merged_v)
  );

  always_comb begin
    acc   = req_valid_i && state_q == S_IDLE;
    f3_ok = req_funct3_i inside {LSU_B, LSU_H, LSU_W} || (!req_we_i && req_funct3_i inside {LSU_BU, LSU_HU});
    bad   = !f3_ok || (req_funct3_i[0] && req_addr_i[0]) || (req_funct3_i[1] && req_addr_i[1:0] != 2'b00) ||
            req_addr_i > XLEN'(MEM_BYTES) - XLEN'(access_size(req_funct3_i));
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (acc) begin
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        word_d  = req_wdata_i;
        rdata_d = '0;
        f3_d    = req_funct3_i;
        we_d    = req_we_i;
        err_d   = bad;
        state_d = bad ? S_RESP : (req_we_i && req_funct3_i == LSU_W) ? S_WR : S_RD;
      end
      S_RD: begin
        word_d  = we_q ? merged_v : ram_data_i;
        rdata_d = we_q ? '0 : load_v;
        state_d = we_q ? S_WR : S_RESP;
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // A reset sampled in WR must suppress the write in that same cycle.
  assign mem_we_o     = state_q == S_WR && !rst_i;
  assign req_ready_o  = state_q == S_IDLE;
  assign resp_valid_o = state_q == S_RESP;
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign resp_err_o   = resp_valid_o && err_q;
  assign ram_addr_o   = (state_q == S_RD || state_q == S_WR) ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign ram_data_o   = state_q == S_WR ? word_q : '0;
endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: randomized scoreboard bench with a byte-array memory reference model.
module tb_lsu_rmw;
  localparam int MB = 4096;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        req_ready_o, resp_valid_o, resp_err_o, mem_we_o;
  logic [31:0] resp_rdata_o, ram_addr_o, ram_data_o, ram_data_i;

  lsu_rmw #(.XLEN(32), .MEM_BYTES(MB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .mem_we_o(mem_we_o), .ram_data_i(ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] ram [MB/4];
  logic [7:0]  rm  [MB];
  assign ram_data_i = ram[ram_addr_o[11:2]];
  always @(posedge clk_i) if (mem_we_o) ram[ram_addr_o[11:2]] <= ram_data_o;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {logic [31:0] rdata; logic err; int cyc;} resp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] wa = a & ~32'd3;
    return {rm[wa], rm[wa+1], rm[wa+2], rm[wa+3]};
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sz, w, acc;
    logic err;
    logic [31:0] v;
    resp_t r;
    wr_t x;
    req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd; req_valid_i = 1'b1;
    for (w = 0; !req_ready_o && w < 20; w++) @(negedge clk_i);
    if (!req_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: ready never rose within 20 cycles");
    end else begin
      chk("one_in_flight", 32'(rq.size() + wq.size()), 32'd0);
      acc = cyc + 1;
      case (f3)
        3'd2:       sz = 4;
        3'd1, 3'd5: sz = 2;
        default:    sz = 1;
      endcase
      err = !(f3 inside {3'd0, 3'd1, 3'd2} || (!we && f3 inside {3'd4, 3'd5})) ||
            (a % sz) != 0 || longint'(a) + sz > MB;
      v = 0;
      if (!err && !we) begin
        for (int i = 0; i < sz; i++) v = (v << 8) | 32'(rm[a+i]);
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
      end
      if (!err && we) begin
        for (int i = 0; i < sz; i++) rm[a+i] = 8'(wd >> (8 * (sz - 1 - i)));
        x.addr = a & ~32'd3; x.data = ref_word(a); x.cyc = acc + (sz == 4 ? 1 : 2);
        wq.push_back(x);
      end
      r.rdata = v; r.err = err;
      r.cyc = acc + (err ? 1 : (we && sz < 4) ? 3 : 2);
      rq.push_back(r);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  resp_t mr;
  wr_t   mw;
  always @(negedge clk_i) if (!rst_i) begin
    if (resp_valid_o) begin
      chk("ready_low_in_resp", 32'(req_ready_o), 32'd0);
      if (rq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_resp: got resp_valid_o=1 expected no response");
      end else begin
        mr = rq.pop_front();
        chk("resp_rdata", resp_rdata_o, mr.rdata);
        chk("resp_err", 32'(resp_err_o), 32'(mr.err));
        chk("resp_cycle", 32'(cyc + 1), 32'(mr.cyc));
      end
    end else chk("resp_idle_zero", resp_rdata_o | 32'(resp_err_o), 32'd0);
    if (mem_we_o) begin
      chk("ready_low_in_wr", 32'(req_ready_o), 32'd0);
      if (wq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got mem_we_o=1 addr %h expected no write", ram_addr_o);
      end else begin
        mw = wq.pop_front();
        chk("wr_addr", ram_addr_o, mw.addr);
        chk("wr_data", ram_data_o, mw.data);
        chk("wr_cycle", 32'(cyc + 1), 32'(mw.cyc));
      end
    end else chk("ram_data_idle_zero", ram_data_o, 32'd0);
  end

  logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    logic [31:0] wv, a;
    int w;
    for (int i = 0; i < MB / 4; i++) begin
      wv = (i == 32'h40) ? 32'h8899AABB : $urandom;
      ram[i] = wv;
      {rm[4*i], rm[4*i+1], rm[4*i+2], rm[4*i+3]} = wv;
    end
    repeat (2) @(negedge clk_i);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_ram_addr", ram_addr_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_reset", 32'(req_ready_o), 32'd1);
    issue(1'b0, 3'd0, 32'h101, 32'h0);
    issue(1'b0, 3'd5, 32'h102, 32'h0);
    issue(1'b0, 3'd1, 32'h100, 32'h0);
    issue(1'b1, 3'd0, 32'h103, 32'h12345677);
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    issue(1'b1, 3'd1, 32'h101, 32'hFFFF);
    issue(1'b0, 3'd2, MB, 32'h0);
    issue(1'b1, 3'd4, 32'h100, 32'h55);
    repeat (4) @(negedge clk_i);
    // SW whose WR cycle is hit by reset: no write, no response.
    req_we_i = 1'b1; req_funct3_i = 3'd2; req_addr_i = 32'h200; req_wdata_i = 32'hDEADBEEF; req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    rst_i = 1'b1;
    #1 chk("rst_kills_we", 32'(mem_we_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("ready_after_mid_rst", 32'(req_ready_o), 32'd1);
    chk("no_resp_after_mid_rst", 32'(resp_valid_o), 32'd0);
    @(negedge clk_i);
    chk("word_unchanged_after_rst", ram[32'h200 >> 2], ref_word(32'h200));
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    issue(1'b1, 3'd0, 32'h102, 32'hA5);
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      w = $urandom_range(0, 9);
      a = w < 8 ? $urandom_range(0, MB - 1) : w == 8 ? $urandom_range(MB - 4, MB + 4) : $urandom;
      issue(1'($urandom), ($urandom_range(0, 4) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)],
            a, $urandom);
    end
    for (w = 0; (rq.size() + wq.size()) != 0 && w < 50; w++) @(negedge clk_i);
    if (rq.size() + wq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d responses and %0d writes still outstanding", rq.size(), wq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
Load/store initiator between the MEM pipeline stage and the data port of the shared instruction/data RAM. The RAM data port reads and writes only whole words, so this block handles sub-word access:
- Loads: extracts the byte or halfword from the read word, with sign or zero extension.
- Sub-word stores: performs a read-modify-write.
- Misaligned or out-of-range requests: flagged as errors, and the RAM is never written.

Parameters:
XLEN, `XLEN (32), data/address width; only 32 supported
MEM_BYTES, `MEM_SIZE, RAM size in bytes; any byte address >= MEM_BYTES is an access error

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  1  request present
req_ready_o  out  1  block can accept (high only in IDLE)
req_we_i  in  1  1=store, 0=load
req_funct3_i  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr_i  in  XLEN  byte address
req_wdata_i  in  XLEN  store data, right-justified
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  XLEN  extended load data (0 for stores/errors)
resp_err_o  out  1  misaligned/out-of-range/illegal funct3, valid with resp_valid_o
ram_addr_o  out  XLEN  word-aligned RAM address {addr[31:2],2'b00}
ram_data_o  out  XLEN  word to write
mem_we_o  out  1  RAM write enable
ram_data_i  in  XLEN  combinational RAM read word

Behaviour:
- Byte order is big-endian within a word.
  - Offset 0 is ram_data_i[31:24] and offset 3 is [7:0].
  - Halfword at offset 0 is [31:16]; at offset 2 it is [15:0].
- FSM states: IDLE, RD, WR, RESP. A request is accepted when req_valid_i && req_ready_o. On accept, addr, funct3, we and wdata are latched.
- Error check at accept:
  - H/HU with addr[0]!=0 is an error.
  - W with addr[1:0]!=0 is an error.
  - addr > MEM_BYTES-size is an error.
  - funct3 not in {000,001,010,100,101} is an error. Stores with funct3 100/101 are also errors.
- IDLE transitions on accept:
  - error -> RESP with err=1.
  - load -> RD.
  - SW -> WR.
  - SB/SH -> RD.
- RD: ram_addr_o = latched word address; ram_data_i is captured into the word register.
  - Load: extract and extend into the rdata register, then -> RESP.
  - Sub-word store: merge the low bits of wdata into the selected lane, then -> WR.
- WR: ram_data_o = merged word (SW: wdata unchanged); mem_we_o=1 for exactly one cycle; then -> RESP.
- RESP: resp_valid_o=1 for one cycle, with rdata/err held from registers; then -> IDLE. There is no response back-pressure.
- Latency from accept edge T to resp_valid_o:
  - load: T+2
  - SW: T+2
  - SB/SH: T+3
  - error: T+1
- Throughput: at most one request in flight. req_ready_o=0 in RD/WR/RESP; the next accept is possible in the cycle after RESP.
- Outputs outside their owning state are 0:
  - ram_addr_o outside RD/WR
  - ram_data_o outside WR
  - mem_we_o outside WR
  - resp_* outside RESP
- mem_we_o = (state==WR) && !rst_i. A reset sampled during WR suppresses that write.
- Reset values: state=IDLE, all registers 0, resp_valid_o=0, mem_we_o=0. req_ready_o=1 in the first cycle after reset is released.
- Reset mid-operation: the request is dropped with no response.
- Address wrap: offset math uses only addr[1:0]. No carry into the word address; no access spans two words.

Decomposition:
- Shared package/defines hold: funct3 encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), the FSM state encoding, and the byte-lane index constants for big-endian order.
- One sub-module, lsu_lane_align: combinational. It takes word, offset and funct3 and produces the extended load value and the merged store word. It is instantiated once, used in RD for both paths, and is unit-testable alone.

Test Plan:
- RAM word 0x100 = 0x8899AABB; LB addr 0x101 -> resp at T+2, rdata=0xFFFFFF99, err=0, mem_we_o never high.
- Same word; LHU addr 0x102 -> rdata=0x0000AABB; LH addr 0x100 -> 0xFFFF8899.
- SB addr 0x103 wdata=0x12345677 -> one mem_we_o pulse at T+2, ram_data_o=0x8899AA77, ram_addr_o=0x100; resp at T+3; follow-up LW 0x100 -> 0x8899AA77.
- SH addr 0x101 -> resp at T+1 with err=1, mem_we_o stays 0. LW addr MEM_BYTES -> err=1. SW with funct3=100 -> err=1.
- SW addr 0x200 wdata=0xDEADBEEF; assert rst_i in the WR cycle -> mem_we_o=0, word unchanged, no resp_valid_o, req_ready_o=1 next cycle.
- Back-to-back: req_valid_i held high with LW then SB -> second accept only in the cycle after the first RESP; req_ready_o low in RD/WR/RESP.
